taus_urng_multi: RTL and testbench



---
 rtl/taus_pkg.sv | 67 ++++++
 rtl/taus_core.sv | 32 +++
 rtl/taus_urng_multi.sv | 105 ++++++++++
 tb/tb_taus_urng_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/taus_pkg.sv
// Shared taus88 constants, state type, FSM encoding and step/seed helpers.
package taus_pkg;

    localparam logic [31:0] TAUS_MASK0 = 32'hFFFFFFFE;
    localparam logic [31:0] TAUS_MASK1 = 32'hFFFFFFF8;
    localparam logic [31:0] TAUS_MASK2 = 32'hFFFFFFF0;

    localparam int unsigned TAUS_SH0_A = 13;
    localparam int unsigned TAUS_SH0_B = 19;
    localparam int unsigned TAUS_SH0_C = 12;
    localparam int unsigned TAUS_SH1_A = 2;
    localparam int unsigned TAUS_SH1_B = 25;
    localparam int unsigned TAUS_SH1_C = 4;
    localparam int unsigned TAUS_SH2_A = 3;
    localparam int unsigned TAUS_SH2_B = 11;
    localparam int unsigned TAUS_SH2_C = 17;

    localparam logic [31:0] TAUS_XOR1 = 32'h10850089;
    localparam logic [31:0] TAUS_XOR2 = 32'h89305309;

    localparam logic [31:0] TAUS_MIN0 = 32'd2;
    localparam logic [31:0] TAUS_MIN1 = 32'd8;
    localparam logic [31:0] TAUS_MIN2 = 32'd16;

    typedef struct packed {
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
    } taus_state_t;

    typedef enum logic [1:0] {
        ST_UNSEEDED,
        ST_WARMUP,
        ST_RUN
    } taus_fsm_t;

    // Each component needs a minimum value or its sequence degenerates.
    function automatic taus_state_t taus_sanitise(input taus_state_t s);
        taus_state_t r;
        r = s;
        if (r.s0 < TAUS_MIN0) r.s0 = r.s0 | TAUS_MIN0;
        if (r.s1 < TAUS_MIN1) r.s1 = r.s1 | TAUS_MIN1;
        if (r.s2 < TAUS_MIN2) r.s2 = r.s2 | TAUS_MIN2;
        return r;
    endfunction

    function automatic taus_state_t taus_expand(input logic [31:0] base);
        taus_state_t r;
        r.s0 = base;
        r.s1 = base ^ TAUS_XOR1;
        r.s2 = base ^ TAUS_XOR2;
        return taus_sanitise(r);
    endfunction

    function automatic taus_state_t taus_step(input taus_state_t s);
        taus_state_t r;
        r.s0 = ((s.s0 & TAUS_MASK0) << TAUS_SH0_C) ^ (((s.s0 << TAUS_SH0_A) ^ s.s0) >> TAUS_SH0_B);
        r.s1 = ((s.s1 & TAUS_MASK1) << TAUS_SH1_C) ^ (((s.s1 << TAUS_SH1_A) ^ s.s1) >> TAUS_SH1_B);
        r.s2 = ((s.s2 & TAUS_MASK2) << TAUS_SH2_C) ^ (((s.s2 << TAUS_SH2_A) ^ s.s2) >> TAUS_SH2_B);
        return r;
    endfunction

    function automatic logic [31:0] taus_sample(input taus_state_t s);
        return s.s0 ^ s.s1 ^ s.s2;
    endfunction

endpackage

// File: rtl/taus_core.sv
// One taus88 channel: state register with seed load and single-step advance.
// o_sample is the sample the state would produce on its next step.
module taus_core
    import taus_pkg::*;
#(
    parameter logic [31:0] CH_OFFSET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_seed,
    output logic [31:0] o_sample
);

    taus_state_t r_state;
    taus_state_t w_next;

    assign w_next   = taus_step(r_state);
    assign o_sample = taus_sample(w_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= taus_expand(CH_OFFSET);
        end else if (i_load) begin
            r_state <= taus_expand(i_seed + CH_OFFSET);
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

endmodule

// File: rtl/taus_urng_multi.sv
// Multi-channel taus88 URNG with seeding, warm-up discard and valid/ready output.
// Optional macro TAUS_CNT_EN adds sample_cnt, the count of accepted handshakes.
module taus_urng_multi
    import taus_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned WARMUP    = 8,
    parameter logic [31:0] CH_STRIDE = 32'h9E3779B9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           seed,
    input  logic                  seed_load,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [NUM_CH*32-1:0]  y,
`ifdef TAUS_CNT_EN
    output logic [31:0]           sample_cnt,
`endif
    output logic                  seeded
);

    taus_fsm_t             r_fsm;
    logic [7:0]            r_warm_cnt;
    logic                  r_out_valid;
    logic                  r_seeded;
    logic [NUM_CH*32-1:0]  r_y;
    logic [NUM_CH*32-1:0]  w_samples;
    logic                  w_adv;
    logic                  w_step;

    assign w_adv  = !r_out_valid || out_ready;
    // Seed load overrides stepping inside the cores, so gate it here too.
    assign w_step = !seed_load &&
                    ((r_fsm == ST_WARMUP) || ((r_fsm == ST_RUN) && w_adv));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        taus_core #(
            .CH_OFFSET (32'(c) * CH_STRIDE)
        ) u_core (
            .clk      (clk),
            .reset    (reset),
            .i_load   (seed_load),
            .i_step   (w_step),
            .i_seed   (seed),
            .o_sample (w_samples[c*32 +: 32])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= ST_UNSEEDED;
            r_warm_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_seeded    <= 1'b0;
            r_y         <= '0;
        end else if (seed_load) begin
            r_fsm       <= (WARMUP > 0) ? ST_WARMUP : ST_RUN;
            r_warm_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_seeded    <= 1'b0;
        end else begin
            case (r_fsm)
                ST_WARMUP: begin
                    if (r_warm_cnt == 8'(WARMUP - 1)) begin
                        r_fsm      <= ST_RUN;
                        r_warm_cnt <= '0;
                        r_seeded   <= 1'b1;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    r_seeded <= 1'b1;
                    if (w_adv) begin
                        r_y         <= w_samples;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TAUS_CNT_EN
    logic [31:0] r_sample_cnt;

    always_ff @(posedge clk) begin
        if (reset || seed_load) begin
            r_sample_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            r_sample_cnt <= r_sample_cnt + 32'd1;
        end
    end

    assign sample_cnt = r_sample_cnt;
`endif

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign seeded    = r_seeded;

endmodule

// File: tb/tb_taus_urng_multi.sv
// Directed bench for taus_urng_multi: WARMUP=0 and WARMUP=8 instances share stimulus.
// Build with TAUS_CNT_EN defined to also check sample_cnt.
module tb_taus_urng_multi;

    logic        clk;
    logic        reset;
    logic [31:0] seed;
    logic        seed_load;
    logic        out_ready;
    logic        v0, v8, sd0, sd8;
    logic [63:0] y0, y8;
`ifdef TAUS_CNT_EN
    logic [31:0] cnt0, cnt8;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [95:0] ms0 [2];
    logic [95:0] ms8 [2];
    logic [63:0] e0, e8;

    taus_urng_multi #(
        .NUM_CH    (2),
        .WARMUP    (0),
        .CH_STRIDE (32'h9E3779B9)
    ) dut0 (
        .clk        (clk),
        .reset      (reset),
        .seed       (seed),
        .seed_load  (seed_load),
        .out_ready  (out_ready),
        .out_valid  (v0),
        .y          (y0),
`ifdef TAUS_CNT_EN
        .sample_cnt (cnt0),
`endif
        .seeded     (sd0)
    );

    taus_urng_multi #(
        .NUM_CH    (2),
        .WARMUP    (8),
        .CH_STRIDE (32'h9E3779B9)
    ) dut8 (
        .clk        (clk),
        .reset      (reset),
        .seed       (seed),
        .seed_load  (seed_load),
        .out_ready  (out_ready),
        .out_valid  (v8),
        .y          (y8),
`ifdef TAUS_CNT_EN
        .sample_cnt (cnt8),
`endif
        .seeded     (sd8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] m_step(input logic [95:0] s);
        logic [31:0] a, b, c;
        a = s[95:64];
        b = s[63:32];
        c = s[31:0];
        a = ((a & 32'hFFFFFFFE) << 12) ^ (((a << 13) ^ a) >> 19);
        b = ((b & 32'hFFFFFFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
        c = ((c & 32'hFFFFFFF0) << 17) ^ (((c << 3)  ^ c) >> 11);
        return {a, b, c};
    endfunction

    function automatic logic [95:0] m_expand(input logic [31:0] sd, input int unsigned ch);
        logic [31:0] base, a, b, c;
        base = sd + 32'(ch) * 32'h9E3779B9;
        a = base;
        b = base ^ 32'h10850089;
        c = base ^ 32'h89305309;
        if (a < 32'd2)  a = a | 32'd2;
        if (b < 32'd8)  b = b | 32'd8;
        if (c < 32'd16) c = c | 32'd16;
        return {a, b, c};
    endfunction

    task automatic m_load(input logic [31:0] sd);
        for (int unsigned ch = 0; ch < 2; ch++) begin
            ms0[ch] = m_expand(sd, ch);
            ms8[ch] = m_expand(sd, ch);
        end
    endtask

    task automatic m_adv(input bit do0, input bit do8);
        for (int unsigned ch = 0; ch < 2; ch++) begin
            if (do0) begin
                ms0[ch] = m_step(ms0[ch]);
                e0[ch*32 +: 32] = ms0[ch][95:64] ^ ms0[ch][63:32] ^ ms0[ch][31:0];
            end
            if (do8) begin
                ms8[ch] = m_step(ms8[ch]);
                e8[ch*32 +: 32] = ms8[ch][95:64] ^ ms8[ch][63:32] ^ ms8[ch][31:0];
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_v0"}, 96'(v0), 96'd0);
        check({tag, "_v8"}, 96'(v8), 96'd0);
        check({tag, "_y0"}, 96'(y0), 96'd0);
        check({tag, "_y8"}, 96'(y8), 96'd0);
        check({tag, "_sd0"}, 96'(sd0), 96'd0);
        check({tag, "_sd8"}, 96'(sd8), 96'd0);
        check({tag, "_st0"}, dut0.g_ch[0].u_core.r_state, {32'h2, 32'h10850089, 32'h89305309});
        check({tag, "_st1"}, dut8.g_ch[1].u_core.r_state, m_expand(32'h0, 1));
    endtask

    // Load a seed, then follow both instances for n cycles with out_ready held high.
    task automatic run_seq(input logic [31:0] sd, input int unsigned n, input bit hand);
        seed      = sd;
        seed_load = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        m_load(sd);
        check("load_v0", 96'(v0), 96'd0);
        check("load_v8", 96'(v8), 96'd0);
        check("load_sd8", 96'(sd8), 96'd0);
`ifdef TAUS_CNT_EN
        check("load_cnt0", 96'(cnt0), 96'd0);
        check("load_cnt8", 96'(cnt8), 96'd0);
`endif
        for (int unsigned k = 1; k <= n; k++) begin
            @(negedge clk);
            m_adv(1'b1, 1'b1);
            check("run_v0", 96'(v0), 96'd1);
            check("run_y0", 96'(y0), 96'(e0));
            if (hand && k == 1) check("hand_y0_ch0", 96'(y0[31:0]), 96'hAE483EF0);
            if (k == 7) check("warm_sd8_lo", 96'(sd8), 96'd0);
            if (k == 8) begin
                check("warm_v8_lo", 96'(v8), 96'd0);
                check("warm_sd8_hi", 96'(sd8), 96'd1);
            end
            if (k == 9) check("warm_v8_hi", 96'(v8), 96'd1);
            if (k >= 9) check("run_y8", 96'(y8), 96'(e8));
`ifdef TAUS_CNT_EN
            if (k == 6) check("cnt0_5", 96'(cnt0), 96'd5);
`endif
        end
    endtask

    task automatic backpressure(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_ready) m_adv(1'b1, 1'b1);
            check("bp_v0", 96'(v0), 96'd1);
            check("bp_v8", 96'(v8), 96'd1);
            check("bp_y0", 96'(y0), 96'(e0));
            check("bp_y8", 96'(y8), 96'(e8));
        end
    endtask

    initial begin
        e0        = '0;
        e8        = '0;
        reset     = 1'b1;
        seed_load = 1'b1;
        seed      = 32'hDEADBEEF;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("rst_load");
        reset     = 1'b0;
        seed_load = 1'b0;
        @(negedge clk);
        check_idle("unseeded_hold");

        run_seq(32'h0, 100, 1'b1);
        run_seq(32'hDEADBEEF, 30, 1'b0);
        backpressure(120);

        run_seq(32'hDEADBEEF, 4, 1'b0);
        run_seq(32'hDEADBEEF, 30, 1'b0);

        reset     = 1'b1;
        seed_load = 1'b1;
        seed      = 32'h12345678;
        @(negedge clk);
        check_idle("rst_mid");
        reset     = 1'b0;
        seed_load = 1'b0;

        run_seq(32'h12345678, 20, 1'b0);
        backpressure(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
